// File: rtl/if_fetch_stage_pkg.sv
// rtl/if_fetch_stage_pkg.sv - shared types and defaults for the instruction-fetch stage
package if_fetch_stage_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FULL  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    // Fetch targets are always word aligned; the low two bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/if_skid_buffer.sv
// rtl/if_skid_buffer.sv - one-entry skid buffer holding {pc4, instr}
module if_skid_buffer #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full
);

    // Single storage slot; clear beats push, push beats pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full <= 1'b0;
            dout <= '0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (push) begin
            full <= 1'b1;
            dout <= din;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

`ifndef SYNTHESIS
    // The fetch FSM stops requesting while the slot is occupied, so a push into a full slot is a bug.
    property no_push_when_full;
        @(posedge clk) disable iff (!rst) !(push && full && !clear);
    endproperty
    assert property (no_push_when_full) else $error("skid buffer written while occupied");
`endif

endmodule

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction fetch: PC, imem handshake, skid buffer, redirect drain
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_pc4,
    output logic [31:0] IF_instr,
    output logic        IF_valid
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  saved_target;
    logic [31:0]  target;
    logic [31:0]  pc_plus4;
    logic         consume;
    logic         accept;
    logic         skid_push;
    logic         skid_pop;
    logic         skid_full;
    logic [63:0]  skid_dout;

    assign target   = word_align(redirect_pc);
    assign pc_plus4 = pc + 32'd4;
    assign consume  = IF_valid & ~stall;

    // In DRAIN the pc still points at the unaccepted request, so the address stays put.
    assign imem_req  = rst & (state != ST_FULL);
    assign imem_addr = pc;
    assign accept    = imem_req & imem_ready;

    assign skid_push = ~redirect & (state == ST_RUN) & accept & IF_valid & stall;
    assign skid_pop  = ~redirect & (state == ST_FULL) & consume;

    if_skid_buffer #(.WIDTH(64)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .push  (skid_push),
        .pop   (skid_pop),
        .clear (redirect),
        .din   ({pc_plus4, imem_rdata}),
        .dout  (skid_dout),
        .full  (skid_full)
    );

    // Fetch FSM together with pc, saved redirect target and the IF/ID-facing output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_RUN;
            pc           <= RESET_PC;
            saved_target <= RESET_PC;
            IF_valid     <= 1'b0;
            IF_pc4       <= 32'd0;
            IF_instr     <= NOP_INSTR;
        end else if (redirect) begin
            IF_valid <= 1'b0;
            IF_instr <= NOP_INSTR;
            case (state)
                ST_RUN: begin
                    if (imem_ready) begin
                        pc <= target;
                    end else begin
                        saved_target <= target;
                        state        <= ST_DRAIN;
                    end
                end
                ST_FULL: begin
                    pc    <= target;
                    state <= ST_RUN;
                end
                default: begin
                    if (imem_ready) begin
                        pc    <= target;
                        state <= ST_RUN;
                    end else begin
                        saved_target <= target;
                    end
                end
            endcase
        end else begin
            case (state)
                ST_RUN: begin
                    if (accept) begin
                        pc <= pc_plus4;
                        if (!IF_valid || consume) begin
                            IF_valid <= 1'b1;
                            IF_pc4   <= pc_plus4;
                            IF_instr <= imem_rdata;
                        end else begin
                            state <= ST_FULL;
                        end
                    end else if (consume) begin
                        IF_valid <= 1'b0;
                        IF_instr <= NOP_INSTR;
                    end
                end
                ST_FULL: begin
                    if (consume) begin
                        IF_valid <= 1'b1;
                        IF_pc4   <= skid_dout[63:32];
                        IF_instr <= skid_dout[31:0];
                        state    <= ST_RUN;
                    end
                end
                default: begin
                    if (consume) begin
                        IF_valid <= 1'b0;
                        IF_instr <= NOP_INSTR;
                    end
                    if (imem_ready) begin
                        pc    <= saved_target;
                        state <= ST_RUN;
                    end
                end
            endcase
        end
    end

    logic unused_skid_full;
    assign unused_skid_full = skid_full;

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - directed self-checking bench for if_fetch_stage
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] IF_pc4;
    logic [31:0] IF_instr;
    logic        IF_valid;

    int checks = 0;
    int errors = 0;

    if_fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .IF_pc4      (IF_pc4),
        .IF_instr    (IF_instr),
        .IF_valid    (IF_valid)
    );

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst         = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        imem_ready  = 1'b0;
        @(negedge clk);
        @(negedge clk);

        chk("rst_req",    {31'd0, imem_req}, 32'd0);
        chk("rst_valid",  {31'd0, IF_valid}, 32'd0);
        chk("rst_pc4",    IF_pc4,            32'd0);
        chk("rst_instr",  IF_instr,          32'd0);

        // 1: zero-wait streaming from reset
        rst        = 1'b1;
        imem_ready = 1'b1;
        #1;
        chk("t1_req0",  {31'd0, imem_req}, 32'd1);
        chk("t1_addr0", imem_addr, 32'h0000_3000);
        step();
        chk("t1_valid1", {31'd0, IF_valid}, 32'd1);
        chk("t1_pc4_1",  IF_pc4,   32'h0000_3004);
        chk("t1_instr1", IF_instr, 32'hA5A5_3000);
        chk("t1_addr1",  imem_addr, 32'h0000_3004);
        step();
        chk("t1_pc4_2",  IF_pc4,   32'h0000_3008);
        chk("t1_addr2",  imem_addr, 32'h0000_3008);
        step();
        chk("t1_pc4_3",  IF_pc4,   32'h0000_300C);
        chk("t1_addr3",  imem_addr, 32'h0000_300C);

        // 2: three-cycle stall, skid fills and request drops
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t2_req_full",  {31'd0, imem_req}, 32'd0);
            chk("t2_pc4_hold",  IF_pc4,   32'h0000_300C);
            chk("t2_instr_hold", IF_instr, 32'hA5A5_3008);
        end
        stall = 1'b0;
        step();
        chk("t2_pc4_skid",   IF_pc4,   32'h0000_3010);
        chk("t2_instr_skid", IF_instr, 32'hA5A5_300C);
        chk("t2_addr_resume", imem_addr, 32'h0000_3010);
        step();
        chk("t2_pc4_next",   IF_pc4,   32'h0000_3014);
        chk("t2_instr_next", IF_instr, 32'hA5A5_3010);

        // 3: redirect with a response in the same cycle
        redirect    = 1'b1;
        redirect_pc = 32'h0000_3100;
        step();
        redirect = 1'b0;
        chk("t3_valid", {31'd0, IF_valid}, 32'd0);
        chk("t3_instr", IF_instr,  32'h0000_0000);
        chk("t3_addr",  imem_addr, 32'h0000_3100);
        step();
        chk("t3_pc4",   IF_pc4,   32'h0000_3104);
        chk("t3_rdata", IF_instr, 32'hA5A5_3100);

        // 5: misaligned redirect target is forced to a word boundary
        redirect    = 1'b1;
        redirect_pc = 32'h0000_3102;
        step();
        redirect = 1'b0;
        chk("t5_addr", imem_addr, 32'h0000_3100);
        step();
        chk("t5_pc4",  IF_pc4,    32'h0000_3104);

        // 4: slow memory, two redirects while the request is outstanding
        imem_ready = 1'b0;
        step();
        chk("t4_addr_wait", imem_addr, 32'h0000_3104);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_3200;
        step();
        chk("t4_drain_addr",  imem_addr, 32'h0000_3104);
        chk("t4_drain_req",   {31'd0, imem_req}, 32'd1);
        chk("t4_drain_valid", {31'd0, IF_valid}, 32'd0);
        redirect_pc = 32'h0000_3300;
        step();
        redirect = 1'b0;
        chk("t4_drain_addr2", imem_addr, 32'h0000_3104);
        step();
        chk("t4_drain_addr3", imem_addr, 32'h0000_3104);
        imem_ready = 1'b1;
        step();
        chk("t4_dropped", {31'd0, IF_valid}, 32'd0);
        chk("t4_latest",  imem_addr, 32'h0000_3300);
        step();
        chk("t4_pc4",  IF_pc4, 32'h0000_3304);

        // 6: stall and redirect together, redirect wins
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_3400;
        step();
        stall    = 1'b0;
        redirect = 1'b0;
        chk("t6_valid", {31'd0, IF_valid}, 32'd0);
        chk("t6_req",   {31'd0, imem_req}, 32'd1);
        chk("t6_addr",  imem_addr, 32'h0000_3400);
        step();
        chk("t6_pc4",   IF_pc4, 32'h0000_3404);

        // 7: asynchronous reset while draining
        imem_ready  = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_3500;
        step();
        redirect = 1'b0;
        chk("t7_drain_addr", imem_addr, 32'h0000_3404);
        #2;
        rst = 1'b0;
        #1;
        chk("t7_async_req",   {31'd0, imem_req}, 32'd0);
        chk("t7_async_valid", {31'd0, IF_valid}, 32'd0);
        chk("t7_async_pc4",   IF_pc4, 32'd0);
        @(negedge clk);
        rst        = 1'b1;
        imem_ready = 1'b1;
        #1;
        chk("t7_first_addr", imem_addr, 32'h0000_3000);

        // 8: pc wraps past the top of the address space
        @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        chk("t8_addr_top", imem_addr, 32'hFFFF_FFFC);
        step();
        chk("t8_addr_wrap", imem_addr, 32'h0000_0000);
        chk("t8_pc4_wrap",  IF_pc4,    32'h0000_0000);
        chk("t8_instr",     IF_instr,  32'h5A5A_FFFC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
